// File: rtl/fp_adder.sv
// fp32 adder, round-to-nearest-even, denormals flushed to zero; one registered stage.
// Latency 1 cycle, one result per cycle, no backpressure.
module fp_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [31:0] result
);

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [30:0] mag_a, mag_b;
  logic        a_big;

  assign sa = data1[31];
  assign sb = data2[31];
  assign ea = data1[30:23];
  assign eb = data2[30:23];
  assign fa = data1[22:0];
  assign fb = data2[22:0];

  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hff) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hff) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hff) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hff) && (fb != 23'd0);

  // Magnitude compare on exp:frac after flushing denormals
  assign mag_a = a_zero ? 31'd0 : data1[30:0];
  assign mag_b = b_zero ? 31'd0 : data2[30:0];
  assign a_big = (mag_a >= mag_b);

  logic        sign_l, sign_s;
  logic [7:0]  exp_l, exp_s, ediff;
  logic [23:0] man_l, man_s;

  assign sign_l = a_big ? sa : sb;
  assign sign_s = a_big ? sb : sa;
  assign exp_l  = a_big ? ea : eb;
  assign exp_s  = a_big ? eb : ea;
  assign man_l  = {1'b1, a_big ? fa : fb};
  assign man_s  = {1'b1, a_big ? fb : fa};
  assign ediff  = exp_l - exp_s;

  logic [49:0] sh_full;
  logic [26:0] aligned_s, big_ext, sub_diff;
  logic [27:0] add_sum;

  assign sh_full   = {man_s, 26'd0} >> ediff;
  // Low 24 bits of the shifted window collapse into the sticky bit
  assign aligned_s = (ediff >= 8'd26) ? 27'd1 : {sh_full[49:24], |sh_full[23:0]};
  assign big_ext   = {man_l, 3'b000};
  assign add_sum   = {1'b0, big_ext} + {1'b0, aligned_s};
  assign sub_diff  = big_ext - aligned_s;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic found;
    lzc27 = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc27 = lzc27 + 5'd1;
      end
    end
  endfunction

  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n, exp_r;
  logic              rnd_inc;
  logic [24:0]       man_r;
  logic [22:0]       frac_out;

  assign lz = lzc27(sub_diff);

  always_comb begin
    norm  = 27'd0;
    exp_n = 10'sd0;
    if (sign_l == sign_s) begin
      if (add_sum[27]) begin
        norm  = {add_sum[27:2], add_sum[1] | add_sum[0]};
        exp_n = $signed({2'b00, exp_l}) + 10'sd1;
      end else begin
        norm  = add_sum[26:0];
        exp_n = $signed({2'b00, exp_l});
      end
    end else begin
      norm  = sub_diff << lz;
      exp_n = $signed({2'b00, exp_l}) - $signed({5'd0, lz});
    end
  end

  assign rnd_inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign man_r    = {1'b0, norm[26:3]} + {24'd0, rnd_inc};
  assign exp_r    = exp_n + $signed({9'd0, man_r[24]});
  assign frac_out = man_r[24] ? man_r[23:1] : man_r[22:0];

  logic [31:0] sum_c;

  always_comb begin
    sum_c = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      sum_c = 32'h7FC0_0000;
    else if (a_inf)
      sum_c = {sa, 8'hff, 23'd0};
    else if (b_inf)
      sum_c = {sb, 8'hff, 23'd0};
    else if (a_zero && b_zero)
      sum_c = {sa & sb, 31'd0};
    else if (a_zero)
      sum_c = data2;
    else if (b_zero)
      sum_c = data1;
    else if ((sign_l != sign_s) && (sub_diff == 27'd0))
      sum_c = 32'h0000_0000;
    else if (exp_n <= 10'sd0)
      sum_c = {sign_l, 31'd0};
    else if (exp_r >= 10'sd255)
      sum_c = {sign_l, 8'hff, 23'd0};
    else
      sum_c = {sign_l, exp_r[7:0], frac_out};
  end

  always_ff @(posedge clk) begin
    if (rst) result <= 32'h0000_0000;
    else     result <= sum_c;
  end

endmodule

// File: tb/tb_fp_adder.sv
// Randomised and directed checks of fp_adder against an exact-integer reference sum.
module tb_fp_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data1, data2;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  fp_adder dut (
    .clk    (clk),
    .rst    (rst),
    .data1  (data1),
    .data2  (data2),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: exact sum as a wide integer scaled by 2^(emin-150), then RNE to 24 bits
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [287:0] ma, mb, mag, rem, half, mant;
    int ea, eb, emin, p, e, sh;
    logic sgn;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
    if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
    if (ea == 0) return b;
    if (eb == 0) return a;
    emin = (ea < eb) ? ea : eb;
    ma = {264'd0, 1'b1, a[22:0]} << (ea - emin);
    mb = {264'd0, 1'b1, b[22:0]} << (eb - emin);
    if (a[31] == b[31]) begin
      mag = ma + mb; sgn = a[31];
    end else if (ma > mb) begin
      mag = ma - mb; sgn = a[31];
    end else if (mb > ma) begin
      mag = mb - ma; sgn = b[31];
    end else begin
      return 32'h0000_0000;
    end
    p = 0;
    for (int i = 0; i < 288; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (e <= 0) return {sgn, 31'd0};
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((288'd1 << sh) - 288'd1);
      half = 288'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 288'd1;
    end
    if (mant[24]) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sgn, 8'hff, 23'd0};
    return {sgn, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic [31:0] r;
    int e;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1: ;
      2, 3, 4: begin
        e = int'(other[30:23]) + $urandom_range(0, 60) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r[30:23] = e[7:0];
      end
      5, 6: begin
        r = {~other[31], other[30:0]};
        if ($urandom_range(0, 1) == 1) r[3:0] = 4'($urandom);
      end
      7: r[30:23] = other[30:23];
      8: r[30:23] = 8'($urandom_range(250, 254));
      default: begin
        case ($urandom_range(0, 4))
          0: r = {r[31], 31'd0};
          1: r = {r[31], 8'h00, r[22:0]};
          2: r = {r[31], 8'hff, 23'd0};
          3: r = {r[31], 8'hff, r[22:0] | 23'd1};
          default: r = {r[31], 8'h01, r[22:0]};
        endcase
      end
    endcase
    return r;
  endfunction

  // Drive at falling edge, result visible just after the next rising edge
  task automatic step(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    data1 = a;
    data2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(32'h3F80_0000, 32'h4000_0000);
    total++;
    if (result !== 32'h0000_0000) begin
      bad++;
      $display("FAIL reset: got %h want 00000000", result);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va [11] = '{32'h42C86666, 32'h4249999A, 32'hC2ACFAE1, 32'hC3F6E666, 32'h42C86666,
                             32'hC2C86666, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00000,
                             32'h80000000};
    logic [31:0] vb [11] = '{32'h42B50000, 32'h42C9999A, 32'hC4163852, 32'hC376E666, 32'hC2B50000,
                             32'h42B50000, 32'hBF800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000,
                             32'h80000000};
    logic [31:0] vr [11] = '{32'h433EB333, 32'h43173334, 32'hC42BD7AE, 32'hC4392CCC, 32'h411B3330,
                             32'hC11B3330, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                             32'h80000000};
    for (int i = 0; i < 11; i++) begin
      step(va[i], vb[i]);
      total++;
      if (result !== vr[i]) begin
        bad++;
        $display("FAIL directed[%0d] %h+%h: got %h want %h", i, va[i], vb[i], result, vr[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [8] = '{32'h00000000, 32'h80000000, 32'h00400000, 32'hFF800000,
                            32'h3F800000, 32'h00000000, 32'h00800000, 32'hFF7FFFFF};
    logic [31:0] vb [8] = '{32'h80000000, 32'hC0400000, 32'h80400000, 32'hC2000000,
                            32'h7F800000, 32'h00000000, 32'h80800001, 32'hFF7FFFFF};
    logic [31:0] vr [8] = '{32'h00000000, 32'hC0400000, 32'h00000000, 32'hFF800000,
                            32'h7F800000, 32'h00000000, 32'h80000000, 32'hFF800000};
    for (int i = 0; i < 8; i++) begin
      step(va[i], vb[i]);
      total++;
      if (result !== vr[i]) begin
        bad++;
        $display("FAIL special[%0d] %h+%h: got %h want %h", i, va[i], vb[i], result, vr[i]);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, exp_r;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(1, 254));
      b = rand_op(a);
      if ($urandom_range(0, 1) == 1) begin
        exp_r = a; a = b; b = exp_r;
      end
      exp_r = ref_add(a, b);
      step(a, b);
      total++;
      if (result !== exp_r) begin
        bad++;
        $display("FAIL random[%0d] %h+%h: got %h want %h", i, a, b, result, exp_r);
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [31:0] a, b, prev, cur;
    prev = result;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      a[30:23] = 8'($urandom_range(100, 150));
      b = rand_op(a);
      cur = ref_add(a, b);
      @(negedge clk);
      total++;
      if (result !== prev) begin
        bad++;
        $display("FAIL b2b_hold[%0d]: got %h want %h", i, result, prev);
      end
      data1 = a;
      data2 = b;
      @(posedge clk);
      #1;
      total++;
      if (result !== cur) begin
        bad++;
        $display("FAIL b2b[%0d] %h+%h: got %h want %h", i, a, b, result, cur);
      end
      prev = cur;
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] a, b, exp_r;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      a[30:23] = 8'($urandom_range(60, 190));
      b = rand_op(a);
      rst = (i == 5 || i == 6);
      exp_r = rst ? 32'h0000_0000 : ref_add(a, b);
      step(a, b);
      total++;
      if (result !== exp_r) begin
        bad++;
        $display("FAIL mid_reset[%0d] rst=%0b %h+%h: got %h want %h", i, rst, a, b, result, exp_r);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    data1 = 32'd0;
    data2 = 32'd0;
    test_reset();
    test_directed();
    test_specials();
    test_random(3000);
    test_back_to_back(200);
    test_mid_reset();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
